gowin_sp: RTL and testbench

- Single-port synchronous block RAM, 2048 x 16 by default, modelling the Gowin BSRAM single-port macro.
- Top level uses it as instruction memory:
  - the boot sequencer writes the program through it;
  - afterwards the CPU fetches through it, addressed by the CPU program counter.
- Read data is registered; an optional second pipeline output stage is selectable by parameter.

---
 rtl/gowin_sp_pkg.sv | 7 +
 rtl/gowin_sp_outreg.sv | 16 +
 rtl/gowin_sp.sv | 55 +++++
 tb/tb_gowin_sp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gowin_sp_pkg.sv
// gowin_sp_pkg: mode encodings and default geometry for the single-port BSRAM model
package gowin_sp_pkg;
    typedef enum logic [0:0] {RD_BYPASS = 1'b0, RD_PIPELINE = 1'b1} read_mode_e;
    typedef enum logic [1:0] {WR_NORMAL = 2'd0, WR_THROUGH = 2'd1, WR_READ_BEFORE = 2'd2} write_mode_e;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
endpackage

// File: rtl/gowin_sp_outreg.sv
// gowin_sp_outreg: enable-gated output register with asynchronous clear
module gowin_sp_outreg
    import gowin_sp_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/gowin_sp.sv
// gowin_sp: single-port synchronous block RAM with selectable write and read modes
module gowin_sp
    import gowin_sp_pkg::*;
#(
    parameter int    ADDR_WIDTH = ADDR_W,
    parameter int    DATA_WIDTH = DATA_W,
    parameter int    READ_MODE  = int'(RD_BYPASS),
    parameter int    WRITE_MODE = int'(WR_NORMAL),
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  oce,
    input  logic                  wre,
    input  logic [ADDR_WIDTH-1:0] ad,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

    if (READ_MODE > int'(RD_PIPELINE) || READ_MODE < 0 ||
        WRITE_MODE > int'(WR_READ_BEFORE) || WRITE_MODE < 0) begin : g_bad_mode
        $error("gowin_sp: illegal READ_MODE or WRITE_MODE");
    end

    mem_t mem = '0;
    logic                  s1_en;
    logic [DATA_WIDTH-1:0] s1_d;
    logic [DATA_WIDTH-1:0] s1_q;

    always_ff @(posedge clk)
        if (ce && wre) mem[ad] <= din;

    // mem[ad] is still the old word at the edge, which gives read-before-write for free
    always_comb begin
        s1_en = ce && !(wre && WRITE_MODE == int'(WR_NORMAL));
        s1_d  = (wre && WRITE_MODE == int'(WR_THROUGH)) ? din : mem[ad];
    end

    gowin_sp_outreg #(.W(DATA_WIDTH)) u_stage1 (
        .clk(clk), .reset(reset), .en(s1_en), .d(s1_d), .q(s1_q)
    );

    if (READ_MODE == int'(RD_PIPELINE)) begin : g_pipe
        gowin_sp_outreg #(.W(DATA_WIDTH)) u_stage2 (
            .clk(clk), .reset(reset), .en(oce), .d(s1_q), .q(dout)
        );
    end else begin : g_bypass
        logic unused_oce;
        assign unused_oce = oce;
        assign dout = s1_q;
    end
endmodule

// File: tb/tb_gowin_sp.sv
// tb_gowin_sp: randomized and directed checks of all write modes and the pipelined read mode
module tb_gowin_sp;
    logic        clk, reset, ce, oce, wre;
    logic [10:0] ad;
    logic [15:0] din;
    logic [15:0] dout0, dout1, dout2, dout3;
    int errors = 0;
    int checks = 0;

    logic [15:0] m [2048];
    bit          wr [2048];
    logic [15:0] e1 [3];
    logic [15:0] e2;
    logic [15:0] prog [14] = '{16'h00A1, 16'h0078, 16'h0066, 16'h0031, 16'h0045, 16'h1234, 16'h0057,
                               16'h00C3, 16'h0019, 16'h00D4, 16'h0023, 16'h0088, 16'h004E, 16'h0092};

    gowin_sp #(.WRITE_MODE(0)) u_wm0 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din), .dout(dout0));
    gowin_sp #(.WRITE_MODE(1)) u_wm1 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din), .dout(dout1));
    gowin_sp #(.WRITE_MODE(2)) u_wm2 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din), .dout(dout2));
    gowin_sp #(.READ_MODE(1))  u_rm1 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din), .dout(dout3));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("wm0", dout0, e1[0]);
        chk("wm1", dout1, e1[1]);
        chk("wm2", dout2, e1[2]);
        chk("rm1", dout3, e2);
    endtask

    task automatic clear_model();
        e1 = '{16'h0, 16'h0, 16'h0};
        e2 = 16'h0;
    endtask

    // One clock: drive inputs, let the edge pass, apply the behavioural rules, compare
    task automatic step(input logic c, input logic w, input logic o, input logic [10:0] a, input logic [15:0] d);
        logic [15:0] old;
        ce = c; wre = w; oce = o; ad = a; din = d;
        @(posedge clk);
        old = m[a];
        if (o) e2 = e1[0];
        if (c) begin
            if (!w) e1 = '{old, old, old};
            else begin
                e1[1] = d;
                e1[2] = old;
            end
        end
        if (c && w) begin
            m[a] = d;
            wr[a] = 1'b1;
        end
        if (reset) clear_model();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset = 1;
        #1;
        chk("rst_async0", dout0, 16'h0);
        chk("rst_async1", dout1, 16'h0);
        chk("rst_async2", dout2, 16'h0);
        chk("rst_async3", dout3, 16'h0);
        clear_model();
        #1 reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            m[i] = 16'h0;
            wr[i] = 1'b0;
        end
        clear_model();
        reset = 1; ce = 0; oce = 0; wre = 0; ad = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dout0, 16'h0);
        chk("reset_state_pipe", dout3, 16'h0);
        reset = 0;

        for (int i = 0; i < 14; i++) begin
            step(1, 1, 1, 11'(i), prog[i]);
            step(0, 0, 1, 11'(i), 16'h0);
        end
        step(1, 0, 1, 11'd0, 16'h0);
        chk("boot_rd0", dout0, 16'h00A1);
        step(1, 0, 1, 11'd13, 16'h0);
        chk("boot_rd13", dout0, 16'h0092);
        chk("pipe_lat2", dout3, 16'h00A1);

        step(1, 0, 1, 11'd3, 16'h0);
        step(1, 1, 1, 11'd5, 16'hBEEF);
        chk("wm0_hold", dout0, 16'h0031);
        chk("wm1_through", dout1, 16'hBEEF);
        chk("wm2_old", dout2, 16'h1234);
        step(1, 0, 1, 11'd5, 16'h0);
        chk("wm0_new", dout0, 16'hBEEF);
        chk("wm1_new", dout1, 16'hBEEF);
        chk("wm2_new", dout2, 16'hBEEF);

        step(1, 0, 1, 11'd7, 16'h0);
        step(0, 1, 1, 11'd8, 16'hFFFF);
        step(0, 1, 1, 11'd100, 16'hFFFF);
        step(0, 1, 1, 11'd7, 16'hFFFF);
        chk("ce0_hold", dout0, 16'h00C3);
        step(1, 0, 1, 11'd8, 16'h0);
        chk("ce0_nowrite8", dout0, 16'h0019);
        step(1, 0, 1, 11'd100, 16'h0);
        chk("ce0_nowrite100", dout0, 16'h0);

        step(1, 0, 1, 11'd0, 16'h0);
        chk("pre_reset", dout0, 16'h00A1);
        async_reset();
        step(1, 0, 1, 11'd0, 16'h0);
        chk("post_reset", dout0, 16'h00A1);

        step(1, 0, 1, 11'd0, 16'h0);
        chk("pipe_rd0", dout3, 16'h00A1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 11'd13, 16'h0);
            chk("pipe_oce0_hold", dout3, 16'h00A1);
        end
        step(1, 0, 1, 11'd13, 16'h0);
        chk("pipe_oce1", dout3, 16'h0092);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) async_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                 11'($urandom_range(0, 63)), 16'($urandom));
        end

        for (int a = 0; a < 2048; a++) begin
            step(1, 0, 1, 11'(a), 16'h0);
            if (!wr[a]) chk("sweep_zero", dout0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
